pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum consecutive dmem-busy cycles before fault.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port decode_i_rs1, input, 5: source register 1 of the instruction in decode.
REQ-005 SHALL have port decode_i_rs2, input, 5: source register 2 of the instruction in decode.
REQ-006 SHALL have port decode_i_rs_used, input, 2: bit0 set = rs1 is read, bit1 set = rs2 is read.
REQ-007 SHALL have port regE_i_mem_rw, input, 4: memory op of the instruction in execute.
REQ-008 SHALL have port regE_i_wb_rd, input, 5: destination register of the instruction in execute.
REQ-009 SHALL have port execute_i_redirect, input, 1: branch/jump mispredict resolved in execute.
REQ-010 SHALL have port memory_i_busy, input, 1: dmem has not completed the access in memory.
REQ-011 SHALL have port ctrl_o_regF_stall, ctrl_o_regD_stall, ctrl_o_regE_stall, ctrl_o_regM_stall, output, 1 each: hold the register.
REQ-012 SHALL have port ctrl_o_regD_bubble, ctrl_o_regE_bubble, ctrl_o_regW_bubble, output, 1 each: load NOP into the register.
REQ-013 SHALL have port ctrl_o_fault, output, 1: sticky dmem-timeout fault.
REQ-014 SHALL have port ctrl_o_stall_cnt, output, 32: count of cycles spent in a load-use or mem-wait stall.

Function
REQ-015 SHALL implement FSM states RUN, MEM_WAIT, FAULT.
REQ-016 SHALL decide load-use as follows: regE_i_mem_rw is a load encoding, regE_i_wb_rd != 0, and wb_rd matches a used decode source.
REQ-017 SHALL compute all stall/bubble outputs combinationally from the current state and current inputs, so they take effect at the next clk edge.
REQ-018 SHALL, in RUN with memory_i_busy=1, assert all four stalls and regW_bubble, and move to MEM_WAIT next cycle with the timeout counter at 1.
REQ-019 SHALL, in MEM_WAIT, hold the same outputs while busy=1 and increment the counter; on busy=0, return to RUN with outputs per RUN rules that cycle.
REQ-020 SHALL move to FAULT when the counter reaches MEM_TIMEOUT while busy=1; FAULT asserts every stall, the fault output stays 1, and only reset exits FAULT.
REQ-021 SHALL, in RUN with busy=0 and execute_i_redirect=1, assert regD_bubble and regE_bubble with no stalls; redirect SHALL take priority over load-use.
REQ-022 SHALL, in RUN with busy=0, redirect=0 and load-use, assert regF_stall, regD_stall and regE_bubble for exactly one cycle.
REQ-023 SHALL apply the priority busy > redirect > load-use; a redirect or load-use raised during MEM_WAIT SHALL be acted on in the first RUN cycle after busy drops, because the held stage registers re-present it.
REQ-024 SHALL never assert a stall and a bubble on the same register in the same cycle.
REQ-025 SHALL increment stall_cnt in every cycle with a load-use or busy stall, wrapping from 0xFFFFFFFF to 0, and SHALL NOT count FAULT cycles.
REQ-026 SHALL make the timeout counter 8 bits wide, or the width needed for MEM_TIMEOUT, and SHALL clear it in every state other than MEM_WAIT.

Reset
REQ-027 SHALL, on rst=0 (async), force the state to RUN, the timeout counter to 0, stall_cnt to 0 and fault to 0.
REQ-028 SHALL hold all stall/bubble outputs at 0 while rst=0, except regD_bubble, regE_bubble and regW_bubble, which SHALL be 1.
REQ-029 SHALL, when rst is asserted mid-MEM_WAIT or in FAULT, return to RUN immediately and drop fault in the same instant.

Structure
REQ-030 SHALL place the mem_rw encodings (mem_no_rw and the load/store codes) and the FSM state enum in the shared pipeline package.
REQ-031 SHALL be implemented as one sub-module, hazard_detect (combinational load-use compare); the FSM and counters remain in pipe_ctrl.

Verification
REQ-032 SHALL cover load-use: LW x5 in E, decode rs1=x5 used -> one cycle of regF_stall=regD_stall=regE_bubble=1, stall_cnt +1.
REQ-033 SHALL cover the x0 case: LW x0 in E, decode rs1=x0 -> no stall.
REQ-034 SHALL cover redirect + load-use in the same cycle -> regD_bubble=regE_bubble=1, no stall.
REQ-035 SHALL cover busy for 3 cycles -> all four stalls plus regW_bubble for 3 cycles, RUN on the 4th cycle, stall_cnt +3.
REQ-036 SHALL cover timeout: MEM_TIMEOUT=4, busy held -> fault=1 after cycle 4, stays 1 after busy drops, cleared only by rst=0.
REQ-037 SHALL cover rst=0 asserted mid-MEM_WAIT -> state RUN, counters 0 and bubbles 1 with no clock edge needed.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared pipeline definitions. Holds the data-memory
//                operation encodings carried in the execute stage register
//                and the state type of the pipeline control FSM.
//  Contents    : MEM_* encodings, ctrl_state_e, is_load()
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Data-memory operation encodings (4 bits, as carried in regE mem_rw).
  // Loads have bit 3 set; stores use the low codes with bit 3 clear.
  localparam logic [3:0] MEM_NO_RW = 4'b0000;
  localparam logic [3:0] MEM_SB    = 4'b0001;
  localparam logic [3:0] MEM_SH    = 4'b0010;
  localparam logic [3:0] MEM_SW    = 4'b0011;
  localparam logic [3:0] MEM_LB    = 4'b1000;
  localparam logic [3:0] MEM_LH    = 4'b1001;
  localparam logic [3:0] MEM_LW    = 4'b1010;
  localparam logic [3:0] MEM_LBU   = 4'b1100;
  localparam logic [3:0] MEM_LHU   = 4'b1101;

  // Pipeline control FSM states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } ctrl_state_e;

  // True only for the defined load codes; undefined codes never stall.
  function automatic logic is_load(input logic [3:0] mem_rw);
    logic r;
    case (mem_rw)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use detector. Flags when the instruction
//                in execute is a load whose destination (non-x0) is read by
//                the instruction in decode.
//  Ports       : rs1_i, rs2_i     - decode source registers
//                rs_used_i        - bit0: rs1 read, bit1: rs2 read
//                mem_rw_i         - memory op of the execute instruction
//                wb_rd_i          - destination of the execute instruction
//                load_use_o       - load-use hazard present
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [1:0] rs_used_i,
  input  logic [3:0] mem_rw_i,
  input  logic [4:0] wb_rd_i,
  output logic       load_use_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = rs_used_i[0] && (rs1_i == wb_rd_i);
  assign w_rs2_hit  = rs_used_i[1] && (rs2_i == wb_rd_i);

  // x0 is never written, so a load targeting it can never feed decode.
  assign load_use_o = is_load(mem_rw_i) && (wb_rd_i != 5'd0) &&
                      (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline stall/bubble controller. Resolves dmem wait,
//                branch redirect and load-use hazards (priority in that
//                order), detects dmem timeouts and counts stall cycles.
//  Ports       : clk, rst (async, active-low)
//                decode_i_rs1/rs2/rs_used - decode operand usage
//                regE_i_mem_rw/wb_rd      - execute-stage load info
//                execute_i_redirect       - mispredict resolved in execute
//                memory_i_busy            - dmem access not complete
//                ctrl_o_reg*_stall        - hold stage register
//                ctrl_o_reg*_bubble       - load NOP into stage register
//                ctrl_o_fault             - sticky dmem timeout
//                ctrl_o_stall_cnt         - load-use + mem-wait stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  decode_i_rs1,
  input  logic [4:0]  decode_i_rs2,
  input  logic [1:0]  decode_i_rs_used,
  input  logic [3:0]  regE_i_mem_rw,
  input  logic [4:0]  regE_i_wb_rd,
  input  logic        execute_i_redirect,
  input  logic        memory_i_busy,
  output logic        ctrl_o_regF_stall,
  output logic        ctrl_o_regD_stall,
  output logic        ctrl_o_regE_stall,
  output logic        ctrl_o_regM_stall,
  output logic        ctrl_o_regD_bubble,
  output logic        ctrl_o_regE_bubble,
  output logic        ctrl_o_regW_bubble,
  output logic        ctrl_o_fault,
  output logic [31:0] ctrl_o_stall_cnt
);

  // Timeout counter is at least 8 bits, wider only if MEM_TIMEOUT needs it.
  localparam int unsigned TW_NEED = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned TW      = (TW_NEED > 8) ? TW_NEED : 8;
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(MEM_TIMEOUT);

  ctrl_state_e   state_q, state_d;
  logic [TW-1:0] tcnt_q,  tcnt_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic          load_use;
  logic          count_stall;
  logic [TW-1:0] tcnt_next;

  hazard_detect u_hazard_detect (
    .rs1_i      (decode_i_rs1),
    .rs2_i      (decode_i_rs2),
    .rs_used_i  (decode_i_rs_used),
    .mem_rw_i   (regE_i_mem_rw),
    .wb_rd_i    (regE_i_wb_rd),
    .load_use_o (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      tcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    tcnt_d             = '0;
    tcnt_next          = '0;
    count_stall        = 1'b0;
    ctrl_o_regF_stall  = 1'b0;
    ctrl_o_regD_stall  = 1'b0;
    ctrl_o_regE_stall  = 1'b0;
    ctrl_o_regM_stall  = 1'b0;
    ctrl_o_regD_bubble = 1'b0;
    ctrl_o_regE_bubble = 1'b0;
    ctrl_o_regW_bubble = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (memory_i_busy) begin
          // Freeze F..M; the stalled memory stage must not retire into W.
          ctrl_o_regF_stall  = 1'b1;
          ctrl_o_regD_stall  = 1'b1;
          ctrl_o_regE_stall  = 1'b1;
          ctrl_o_regM_stall  = 1'b1;
          ctrl_o_regW_bubble = 1'b1;
          count_stall        = 1'b1;
          // tcnt_next is the number of consecutive busy cycles including
          // this one; the fault fires on the edge ending the last allowed one.
          tcnt_next = (state_q == ST_RUN) ? TW'(1) : (tcnt_q + TW'(1));
          if (tcnt_next >= TIMEOUT_LIM) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_MEM_WAIT;
            tcnt_d  = tcnt_next;
          end
        end else begin
          // Redirect or load-use held during a wait is re-presented by the
          // frozen stage registers, so it is handled here on the exit cycle.
          state_d = ST_RUN;
          if (execute_i_redirect) begin
            ctrl_o_regD_bubble = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
          end else if (load_use) begin
            ctrl_o_regF_stall  = 1'b1;
            ctrl_o_regD_stall  = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
            count_stall        = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        // Whole pipe frozen until reset; W keeps receiving NOPs.
        ctrl_o_regF_stall  = 1'b1;
        ctrl_o_regD_stall  = 1'b1;
        ctrl_o_regE_stall  = 1'b1;
        ctrl_o_regM_stall  = 1'b1;
        ctrl_o_regW_bubble = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    stall_cnt_d = stall_cnt_q + {31'd0, count_stall};

    // While in reset the pipe is flushed without waiting for a clock edge.
    if (!rst) begin
      ctrl_o_regF_stall  = 1'b0;
      ctrl_o_regD_stall  = 1'b0;
      ctrl_o_regE_stall  = 1'b0;
      ctrl_o_regM_stall  = 1'b0;
      ctrl_o_regD_bubble = 1'b1;
      ctrl_o_regE_bubble = 1'b1;
      ctrl_o_regW_bubble = 1'b1;
    end
  end

  assign ctrl_o_fault     = (state_q == ST_FAULT);
  assign ctrl_o_stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl. Expected
//                outputs are queued as each step is driven and popped when
//                the outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  // Output vector order: {F_st, D_st, E_st, M_st, D_bub, E_bub, W_bub}
  localparam logic [6:0] CT_IDLE = 7'b0000000;
  localparam logic [6:0] CT_LU   = 7'b1100010;
  localparam logic [6:0] CT_RED  = 7'b0000110;
  localparam logic [6:0] CT_BUSY = 7'b1111001;
  localparam logic [6:0] CT_RST  = 7'b0000111;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, wb_rd;
  logic [1:0]  rs_used;
  logic [3:0]  mem_rw;
  logic        redirect, busy;
  logic        f_st, d_st, e_st, m_st, d_bub, e_bub, w_bub, fault;
  logic [31:0] stall_cnt;

  typedef struct {
    string       tag;
    logic [6:0]  ctrl;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          tests;
  int          failed;
  logic [31:0] exp_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .decode_i_rs1       (rs1),
    .decode_i_rs2       (rs2),
    .decode_i_rs_used   (rs_used),
    .regE_i_mem_rw      (mem_rw),
    .regE_i_wb_rd       (wb_rd),
    .execute_i_redirect (redirect),
    .memory_i_busy      (busy),
    .ctrl_o_regF_stall  (f_st),
    .ctrl_o_regD_stall  (d_st),
    .ctrl_o_regE_stall  (e_st),
    .ctrl_o_regM_stall  (m_st),
    .ctrl_o_regD_bubble (d_bub),
    .ctrl_o_regE_bubble (e_bub),
    .ctrl_o_regW_bubble (w_bub),
    .ctrl_o_fault       (fault),
    .ctrl_o_stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (obs=running exp=done)");
    $fatal(1, "watchdog expired");
  end

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [1:0] used, input logic [3:0] rw,
                        input logic [4:0] rd, input logic red, input logic bz);
    rs1 = a1; rs2 = a2; rs_used = used; mem_rw = rw; wb_rd = rd;
    redirect = red; busy = bz;
  endtask

  task automatic push_exp(input string tag, input logic [6:0] ctrl,
                          input logic f, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.ctrl = ctrl; e.fault = f; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t       e;
    logic [6:0] obs;
    e   = sb.pop_front();
    obs = {f_st, d_st, e_st, m_st, d_bub, e_bub, w_bub};
    tests++;
    assert (obs === e.ctrl) else begin
      failed++;
      $error("FAIL %s ctrl: observed=%b expected=%b", e.tag, obs, e.ctrl);
    end
    tests++;
    assert (fault === e.fault) else begin
      failed++;
      $error("FAIL %s fault: observed=%b expected=%b", e.tag, fault, e.fault);
    end
    tests++;
    assert (stall_cnt === e.cnt) else begin
      failed++;
      $error("FAIL %s stall_cnt: observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
    end
  endtask

  // One clock cycle: queue expectation, sample mid-cycle, advance past edge.
  task automatic cyc(input string tag, input logic [6:0] ctrl,
                     input logic f, input logic incr);
    push_exp(tag, ctrl, f, exp_cnt);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
    if (incr) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Check without any clock edge (asynchronous reset behaviour).
  task automatic chk_now(input string tag, input logic [6:0] ctrl,
                         input logic f, input logic [31:0] cnt);
    push_exp(tag, ctrl, f, cnt);
    compare_head();
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    exp_cnt = 32'd0;
    rst     = 1'b0;
    set_in(5'd0, 5'd0, 2'b00, MEM_NO_RW, 5'd0, 1'b0, 1'b0);

    // Reset state, before and after clock edges
    #3;
    chk_now("reset_t0", CT_RST, 1'b0, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk_now("reset_held", CT_RST, 1'b0, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    cyc("idle", CT_IDLE, 1'b0, 1'b0);

    // Load-use on rs1, then the bubble has reached E
    set_in(5'd5, 5'd0, 2'b01, MEM_LW, 5'd5, 1'b0, 1'b0);
    cyc("lu_rs1", CT_LU, 1'b0, 1'b1);
    set_in(5'd5, 5'd0, 2'b01, MEM_NO_RW, 5'd0, 1'b0, 1'b0);
    cyc("lu_after", CT_IDLE, 1'b0, 1'b0);

    // Load-use on rs2; same register but rs2 not read
    set_in(5'd0, 5'd7, 2'b10, MEM_LBU, 5'd7, 1'b0, 1'b0);
    cyc("lu_rs2", CT_LU, 1'b0, 1'b1);
    set_in(5'd0, 5'd7, 2'b01, MEM_LBU, 5'd7, 1'b0, 1'b0);
    cyc("rs2_unused", CT_IDLE, 1'b0, 1'b0);

    // Load to x0 and store are never load-use
    set_in(5'd0, 5'd0, 2'b11, MEM_LW, 5'd0, 1'b0, 1'b0);
    cyc("x0_load", CT_IDLE, 1'b0, 1'b0);
    set_in(5'd5, 5'd0, 2'b01, MEM_SW, 5'd5, 1'b0, 1'b0);
    cyc("store", CT_IDLE, 1'b0, 1'b0);

    // Redirect beats load-use
    set_in(5'd5, 5'd0, 2'b01, MEM_LW, 5'd5, 1'b1, 1'b0);
    cyc("redir_lu", CT_RED, 1'b0, 1'b0);

    // Busy 3 cycles with a load-use pending, then load-use acted on
    set_in(5'd9, 5'd0, 2'b01, MEM_LH, 5'd9, 1'b0, 1'b1);
    cyc("busy1", CT_BUSY, 1'b0, 1'b1);
    cyc("busy2", CT_BUSY, 1'b0, 1'b1);
    cyc("busy3", CT_BUSY, 1'b0, 1'b1);
    busy = 1'b0;
    cyc("busy_exit_lu", CT_LU, 1'b0, 1'b1);
    set_in(5'd0, 5'd0, 2'b00, MEM_NO_RW, 5'd0, 1'b0, 1'b0);
    cyc("post_busy", CT_IDLE, 1'b0, 1'b0);

    // Redirect raised during a wait is acted on at exit
    set_in(5'd0, 5'd0, 2'b00, MEM_NO_RW, 5'd0, 1'b1, 1'b1);
    cyc("busy_red1", CT_BUSY, 1'b0, 1'b1);
    cyc("busy_red2", CT_BUSY, 1'b0, 1'b1);
    busy = 1'b0;
    cyc("busy_exit_red", CT_RED, 1'b0, 1'b0);
    redirect = 1'b0;

    // Reset asserted in MEM_WAIT, no clock edge needed
    busy = 1'b1;
    cyc("wait_enter", CT_BUSY, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    exp_cnt = 32'd0;
    chk_now("rst_mid_wait", CT_RST, 1'b0, 32'd0);
    busy = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cyc("after_rst", CT_IDLE, 1'b0, 1'b0);

    // Timeout with MEM_TIMEOUT=4: fault after the 4th busy cycle
    busy = 1'b1;
    cyc("to_busy1", CT_BUSY, 1'b0, 1'b1);
    cyc("to_busy2", CT_BUSY, 1'b0, 1'b1);
    cyc("to_busy3", CT_BUSY, 1'b0, 1'b1);
    cyc("to_busy4", CT_BUSY, 1'b0, 1'b1);
    cyc("fault_busy", CT_BUSY, 1'b1, 1'b0);
    busy = 1'b0;
    cyc("fault_sticky", CT_BUSY, 1'b1, 1'b0);
    set_in(5'd5, 5'd0, 2'b01, MEM_LW, 5'd5, 1'b1, 1'b0);
    cyc("fault_ignores", CT_BUSY, 1'b1, 1'b0);
    set_in(5'd0, 5'd0, 2'b00, MEM_NO_RW, 5'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    exp_cnt = 32'd0;
    chk_now("rst_fault", CT_RST, 1'b0, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cyc("run_again", CT_IDLE, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
